// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one FIFO per result producer, round-robin
// selection and a registered single write port toward the register file.
// Optional macro WB_PENDING_EN adds the 'pending' per-register hazard vector.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      register_load,
  output logic [ADDR_W-1:0]         address_D,
  output logic [DATA_W-1:0]         bus_D,
`ifdef WB_PENDING_EN
  output logic [(2**ADDR_W)-1:0]    pending,
`endif
  output logic                      busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [SrcW-1:0] src_t;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] mem_addr_q [NUM_SRC][FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [NUM_SRC][FIFO_DEPTH];
  ptr_t              rd_ptr_q   [NUM_SRC];
  ptr_t              rd_ptr_d   [NUM_SRC];
  ptr_t              wr_ptr_q   [NUM_SRC];
  ptr_t              wr_ptr_d   [NUM_SRC];
  cnt_t              count_q    [NUM_SRC];
  cnt_t              count_d    [NUM_SRC];

  // Arbitration state
  src_t              rr_q, rr_d;
  logic              grant_valid;
  src_t              grant_idx;
  logic [NUM_SRC-1:0] push, pop;
  logic [ADDR_W-1:0] pop_addr;
  logic [DATA_W-1:0] pop_data;

  // Output register
  logic              register_load_q, register_load_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Ready depends only on registered occupancy; a full FIFO never passes through
  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] != cnt_t'(FIFO_DEPTH));
    end
    push = src_valid & src_ready;
  end

  // Round-robin: first non-empty FIFO after the last granted index, with wrap
  always_comb begin
    int unsigned idx;
    src_t        cand;
    idx         = 0;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = rr_q;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = 32'(rr_q) + off;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      cand = src_t'(idx);
      if (!grant_valid && (count_q[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    pop = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && (grant_idx == src_t'(i));
    end
    pop_addr = mem_addr_q[grant_idx][rd_ptr_q[grant_idx]];
    pop_data = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
    rr_d     = grant_valid ? grant_idx : rr_q;
  end

  // FIFO next state: push writes at the tail, pop advances the head
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (push[i]) begin
        mem_addr_d[i][wr_ptr_q[i]] = src_addr[i*ADDR_W +: ADDR_W];
        mem_data_d[i][wr_ptr_q[i]] = src_data[i*DATA_W +: DATA_W];
        wr_ptr_d[i]                = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      count_d[i] = count_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
    end
  end

  // Output register next state; address 0 consumes a slot but never loads
  always_comb begin
    register_load_d = grant_valid && (pop_addr != '0);
    address_d       = grant_valid ? pop_addr : address_q;
    data_d          = grant_valid ? pop_data : data_q;
    busy_d          = register_load_d;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (count_d[i] != '0) begin
        busy_d = 1'b1;
      end
    end
  end

  // Control state with asynchronous clear; buffered writes are dropped on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q            <= src_t'(NUM_SRC - 1);
      register_load_q <= 1'b0;
      address_q       <= '0;
      data_q          <= '0;
      busy_q          <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_q            <= rr_d;
      register_load_q <= register_load_d;
      address_q       <= address_d;
      data_q          <= data_d;
      busy_q          <= busy_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Entry storage needs no reset: contents are only observed under count_q
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign register_load = register_load_q;
  assign address_D     = address_q;
  assign bus_D         = data_q;
  assign busy          = busy_q;

`ifdef WB_PENDING_EN
  // Outstanding-write vector: live FIFO entries plus a loading output register
  always_comb begin
    ptr_t occ_off;
    occ_off = '0;
    pending = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        occ_off = ptr_t'(k) - rd_ptr_q[i];
        if ({1'b0, occ_off} < count_q[i]) begin
          pending[mem_addr_q[i][k]] = 1'b1;
        end
      end
    end
    if (register_load_q) begin
      pending[address_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end
`endif

endmodule
